// File: rtl/cdc_ack_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : cdc_ack_arbiter
// Purpose  : Round-robin arbiter that forwards one requester payload at a time
//            over a 2FF-with-ack CDC channel using a 4-phase return-to-zero
//            handshake (IDLE -> SEND -> CLEAR -> IDLE).
// Ports    : arst_a      async active-high reset
//            clk_a_in    clock (rising edge)
//            req_i       per-requester level request, held until gnt_o
//            data_i      packed payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//            gnt_o       one-hot pulse: payload of that requester sampled
//            done_o      one-hot pulse: transfer of that requester complete
//            err_o       pulse: SEND phase timed out waiting for ack
//            busy_o      high whenever the FSM is not idle
//            cdc_data_o  registered channel word, MSB = valid flag
//            cdc_ack_i   channel ack, already synchronised to clk_a_in
// Revision : 1.0  initial release
// ============================================================================
module cdc_ack_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          arst_a,
    input  logic                          clk_a_in,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          err_o,
    output logic                          busy_o,
    output logic [DATA_WIDTH:0]           cdc_data_o,
    input  logic                          cdc_ack_i
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [NUM_REQ-1:0] c_one     = NUM_REQ'(1);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt,      w_cnt_nxt;
    logic [c_ptr_w-1:0]    r_rr_ptr,   w_rr_nxt;
    logic [c_ptr_w-1:0]    r_owner,    w_owner_nxt;
    logic [DATA_WIDTH:0]   r_cdc_data, w_data_nxt;
    logic [NUM_REQ-1:0]    r_gnt,      w_gnt_nxt;
    logic [NUM_REQ-1:0]    r_done,     w_done_nxt;
    logic                  r_err,      w_err_nxt;

    // Round-robin search result
    logic                  w_found;
    logic [c_ptr_w-1:0]    w_sel;
    logic [DATA_WIDTH-1:0] w_sel_data;
    int                    w_idx;

    // Scan requesters starting at the round-robin pointer, wrapping at NUM_REQ.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        w_idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_i[w_idx]) begin
                w_found    = 1'b1;
                w_sel      = w_idx[c_ptr_w-1:0];
                w_sel_data = data_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_data_nxt  = r_cdc_data;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_SEND;
                    w_gnt_nxt   = c_one << w_sel;
                    w_owner_nxt = w_sel;
                    // Valid flag guarantees a channel ack even for zero payloads.
                    w_data_nxt  = {1'b1, w_sel_data};
                    w_cnt_nxt   = '0;
                end
            end
            S_SEND: begin
                // Ack takes priority over a coincident timeout.
                if (cdc_ack_i) begin
                    w_data_nxt  = '0;
                    w_state_nxt = S_CLEAR;
                end else if (r_cnt == c_cnt_max) begin
                    w_err_nxt   = 1'b1;
                    w_data_nxt  = '0;
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            S_CLEAR: begin
                // Return-to-zero phase: wait as long as the channel needs.
                if (!cdc_ack_i) begin
                    w_done_nxt  = c_one << r_owner;
                    w_rr_nxt    = (r_owner == c_last) ? '0 : r_owner + c_ptr_w'(1);
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_a_in or posedge arst_a) begin
        if (arst_a) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_cdc_data <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_cdc_data <= w_data_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign gnt_o      = r_gnt;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign busy_o     = (r_state != S_IDLE);
    assign cdc_data_o = r_cdc_data;

endmodule
`default_nettype wire

// File: tb/tb_cdc_ack_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_cdc_ack_arbiter
// Purpose  : Directed self-checking bench for cdc_ack_arbiter
//            (NUM_REQ=4, DATA_WIDTH=8, TIMEOUT_CYCLES=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_cdc_ack_arbiter;

    logic        clk_a_in;
    logic        arst_a;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic        err_o;
    logic        busy_o;
    logic [8:0]  cdc_data_o;
    logic        cdc_ack_i;

    int n_total = 0;
    int n_bad   = 0;

    cdc_ack_arbiter #(
        .DATA_WIDTH     (8),
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .arst_a     (arst_a),
        .clk_a_in   (clk_a_in),
        .req_i      (req_i),
        .data_i     (data_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .cdc_data_o (cdc_data_o),
        .cdc_ack_i  (cdc_ack_i)
    );

    initial clk_a_in = 1'b0;
    always #5 clk_a_in = ~clk_a_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transfer with the channel acking ack_dly cycles per phase.
    task automatic xfer(input logic [3:0] exp_gnt, input logic [8:0] exp_data,
                        input int ack_dly, input bit drop_req);
        @(negedge clk_a_in);
        check_eq("gnt", 32'(gnt_o), 32'(exp_gnt));
        check_eq("send_data", 32'(cdc_data_o), 32'(exp_data));
        check_eq("busy_send", 32'(busy_o), 32'd1);
        if (drop_req) req_i = 4'b0000;
        for (int i = 1; i < ack_dly; i++) begin
            @(negedge clk_a_in);
            check_eq("send_hold", 32'(cdc_data_o), 32'(exp_data));
        end
        cdc_ack_i = 1'b1;
        @(negedge clk_a_in);
        check_eq("clear_data", 32'(cdc_data_o), 32'd0);
        check_eq("clear_err", 32'(err_o), 32'd0);
        for (int i = 1; i < ack_dly; i++) @(negedge clk_a_in);
        cdc_ack_i = 1'b0;
        @(negedge clk_a_in);
        check_eq("done", 32'(done_o), 32'(exp_gnt));
        check_eq("gnt_with_done", 32'(gnt_o), 32'd0);
        check_eq("busy_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        arst_a    = 1'b1;
        req_i     = 4'b0000;
        data_i    = 32'h0;
        cdc_ack_i = 1'b0;

        // Reset state, including clocks running with requests pending
        repeat (2) @(negedge clk_a_in);
        check_eq("rst_data", 32'(cdc_data_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_err",  32'(err_o), 32'd0);
        req_i = 4'b1111;
        repeat (2) @(negedge clk_a_in);
        check_eq("rst_gnt", 32'(gnt_o), 32'd0);
        req_i  = 4'b0000;
        arst_a = 1'b0;

        // Single transfer of an all-zero payload from requester 2
        data_i = {8'h13, 8'h00, 8'h11, 8'h10};
        req_i  = 4'b0100;
        xfer(4'b0100, 9'h100, 3, 1'b1);

        // Pointer now 3: requester 3 wins over 0 and 1
        req_i = 4'b1011;
        xfer(4'b1000, 9'h113, 2, 1'b1);

        // Round robin with all requests held
        req_i = 4'b1111;
        xfer(4'b0001, 9'h110, 2, 1'b0);
        xfer(4'b0010, 9'h111, 2, 1'b0);
        xfer(4'b0100, 9'h100, 2, 1'b0);
        xfer(4'b1000, 9'h113, 2, 1'b0);
        xfer(4'b0001, 9'h110, 2, 1'b1);

        // Timeout with ack held low (pointer at 1, only requester 0 asking)
        data_i[7:0] = 8'hA5;
        req_i       = 4'b0001;
        @(negedge clk_a_in);
        check_eq("to_gnt", 32'(gnt_o), 32'b0001);
        req_i = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk_a_in);
            check_eq("to_send_data", 32'(cdc_data_o), 32'h1A5);
            check_eq("to_no_err", 32'(err_o), 32'd0);
        end
        @(negedge clk_a_in);
        check_eq("to_err", 32'(err_o), 32'd1);
        check_eq("to_clear_data", 32'(cdc_data_o), 32'd0);
        check_eq("to_no_done_yet", 32'(done_o), 32'd0);
        @(negedge clk_a_in);
        check_eq("to_done", 32'(done_o), 32'b0001);
        check_eq("to_err_pulse", 32'(err_o), 32'd0);

        // Ack arriving in the last SEND cycle beats the timeout
        data_i[15:8] = 8'h77;
        req_i        = 4'b0010;
        @(negedge clk_a_in);
        check_eq("race_gnt", 32'(gnt_o), 32'b0010);
        req_i = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk_a_in);
            check_eq("race_send_data", 32'(cdc_data_o), 32'h177);
        end
        cdc_ack_i = 1'b1;
        @(negedge clk_a_in);
        check_eq("race_no_err", 32'(err_o), 32'd0);
        check_eq("race_clear_data", 32'(cdc_data_o), 32'd0);
        check_eq("race_busy", 32'(busy_o), 32'd1);
        cdc_ack_i = 1'b0;
        @(negedge clk_a_in);
        check_eq("race_done", 32'(done_o), 32'b0010);

        // Payload latched at grant despite data_i churn, then reset mid-SEND
        data_i[15:8] = 8'h3C;
        req_i        = 4'b0010;
        @(negedge clk_a_in);
        check_eq("stab_gnt", 32'(gnt_o), 32'b0010);
        check_eq("stab_data0", 32'(cdc_data_o), 32'h13C);
        req_i = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            data_i[15:8] = 8'($urandom);
            @(negedge clk_a_in);
            check_eq("stab_hold", 32'(cdc_data_o), 32'h13C);
        end
        #2 arst_a = 1'b1;
        #1;
        check_eq("arst_data", 32'(cdc_data_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_a_in);
            check_eq("arst_no_done", 32'(done_o), 32'd0);
        end
        arst_a = 1'b0;
        req_i  = 4'b1010;
        @(negedge clk_a_in);
        check_eq("post_rst_gnt", 32'(gnt_o), 32'b0010);
        check_eq("post_rst_done", 32'(done_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdc_ack_arbiter.md
CDC_ACK_ARBITER -- requirements
Module: cdc_ack_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits, >=1.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: SEND-state ack wait limit in clk_a_in cycles, >=4.
REQ-004 SHALL have port arst_a  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clk_a_in  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port req_i  input  NUM_REQ  per-requester transfer request, level, held until gnt_o.
REQ-007 SHALL have port data_i  input  NUM_REQ*DATA_WIDTH  payloads; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port gnt_o  output  NUM_REQ  one-hot, one-cycle pulse: payload of that requester sampled.
REQ-009 SHALL have port done_o  output  NUM_REQ  one-hot, one-cycle pulse: transfer of that requester complete.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse: SEND timed out.
REQ-011 SHALL have port busy_o  output  1  high whenever state != IDLE.
REQ-012 SHALL have port cdc_data_o  output  DATA_WIDTH+1  registered word to the 2FF-with-ack channel data input; MSB = valid flag.
REQ-013 SHALL have port cdc_ack_i  input  1  ack from the channel, already synchronised to clk_a_in.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, CLEAR (4-phase return-to-zero handshake over the shared channel).
REQ-015 IDLE: if any req_i bit high, SHALL grant the first requester at or above round-robin pointer rr_ptr (wrapping NUM_REQ-1 -> 0), pulse its gnt_o bit, load cdc_data_o = {1'b1, data_i[k]} and go to SEND on the same edge.
REQ-016 cdc_data_o MSB SHALL be 1 throughout SEND so the channel acks even for all-zero payloads.
REQ-017 cdc_data_o SHALL be constant throughout SEND (latched at grant, independent of later data_i/req_i changes).
REQ-018 SEND: when cdc_ack_i==1, SHALL load cdc_data_o = 0 and go to CLEAR.
REQ-019 SEND: wait counter SHALL clear on entry and increment each SEND cycle with ack low; when it reaches TIMEOUT_CYCLES-1 with ack still low, SHALL pulse err_o, load cdc_data_o = 0, go to CLEAR.
REQ-020 Ack and timeout in the same cycle: ack SHALL win, err_o SHALL stay low.
REQ-021 CLEAR: when cdc_ack_i==0, SHALL pulse done_o[owner] (also after a timeout), set rr_ptr = (owner+1) mod NUM_REQ, go to IDLE.
REQ-022 CLEAR SHALL have no timeout; it waits indefinitely for ack low.
REQ-023 A new grant SHALL NOT occur in the cycle done_o pulses; earliest next gnt_o is the following cycle.
REQ-024 req_i dropped before its grant SHALL produce no transfer; req_i changes outside IDLE SHALL be ignored.
REQ-025 At most one gnt_o, done_o bit high per cycle; gnt_o/done_o SHALL never pulse together.
REQ-026 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits, rr_ptr width $clog2(NUM_REQ) (min 1) bits; rr_ptr SHALL never exceed NUM_REQ-1.

Reset
REQ-027 arst_a high SHALL immediately force state IDLE, cdc_data_o=0, gnt_o=0, done_o=0, err_o=0, busy_o=0, rr_ptr=0, counter=0.
REQ-028 Reset mid-transfer SHALL abandon it with no done_o; first grant after release SHALL follow rr_ptr=0 priority.
REQ-029 Outputs SHALL leave reset values only on the first clk_a_in edge after arst_a deasserts.

Verification (NUM_REQ=4, DATA_WIDTH=8, TIMEOUT_CYCLES=16)
REQ-030 Single transfer: req_i=4'b0100, data_i[2]=8'h00, ack rises 3 cycles after grant, falls 3 after clear -> gnt_o=4'b0100, cdc_data_o=9'h100 until ack, then 0, done_o=4'b0100 pulse, rr_ptr=3.
REQ-031 Round robin: req_i=4'b1111 held, channel model acks 2 cycles per phase -> grant order 0,1,2,3,0; each done_o before next gnt_o.
REQ-032 Timeout: req_i=4'b0001, data 8'hA5, ack held 0 -> cdc_data_o=9'h1A5 for 16 cycles, err_o pulse, cdc_data_o=0, done_o=4'b0001 next cycle.
REQ-033 Race: ack rises in the 16th SEND cycle -> no err_o, normal CLEAR and done_o.
REQ-034 Reset mid-SEND: assert arst_a with cdc_data_o=9'h13C -> cdc_data_o=0, busy_o=0 immediately, no done_o; after release req_i=4'b1010 -> first gnt_o=4'b0010.
REQ-035 Data stability: change data_i[1] every cycle during SEND -> cdc_data_o holds the grant-cycle value.
